// File: rtl/addsub_arbiter_pkg.sv
// Shared encodings for the add/sub arbiter: operation codes and sequencer states.
package addsub_arbiter_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Requester and response bus of the shared add/sub unit.
interface addsub_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_carry;
  logic                  rsp_ovf;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf
  );
endinterface

// File: rtl/addsub_arbiter_register.sv
// Enable register with asynchronous active-low clear.
module register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one registered add/sub datapath among NREQ requesters.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input logic              clk,
  input logic              rst,
  addsub_arbiter_if.slave  bus
);

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  w_winner;
  logic [IDW:0]    w_cand;
  logic            w_found;
  logic            w_idle;
  logic            w_hs;
  logic [NREQ-1:0] w_ready;
  logic [WIDTH-1:0] w_a_sel, w_b_sel;
  logic            w_op_sel;

  logic [WIDTH-1:0] w_a, w_b, w_bop;
  logic [IDW:0]     w_opid;
  logic             w_op;
  logic [IDW-1:0]   w_id;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH+1:0] w_res_q;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_cand >= (IDW+1)'(NREQ)) w_cand = w_cand - (IDW+1)'(NREQ);
      if (bus.req_valid[w_cand[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_a_sel  = '0;
    w_b_sel  = '0;
    w_op_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_a_sel  = bus.req_a[i*WIDTH +: WIDTH];
        w_b_sel  = bus.req_b[i*WIDTH +: WIDTH];
        w_op_sel = bus.req_op[i];
      end
    end
  end

  // Ready is withheld while reset is asserted, not just once the state clears.
  assign w_idle = (r_state == IDLE) && rst;
  assign w_hs   = w_idle && w_found;

  always_comb begin
    w_ready = '0;
    if (w_hs) w_ready[w_winner] = 1'b1;
  end
  assign bus.req_ready = w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_hs) w_state_nxt = LOAD;
      LOAD: w_state_nxt = EXEC;
      EXEC: w_state_nxt = RESP;
      RESP: if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rr_ptr <= '0;
    else if (w_hs) r_rr_ptr <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
  end

  register #(.W(WIDTH)) u_reg_a (
    .clk(clk), .rst(rst), .i_en(w_hs), .i_d(w_a_sel), .o_q(w_a)
  );
  register #(.W(WIDTH)) u_reg_b (
    .clk(clk), .rst(rst), .i_en(w_hs), .i_d(w_b_sel), .o_q(w_b)
  );
  register #(.W(IDW+1)) u_reg_opid (
    .clk(clk), .rst(rst), .i_en(w_hs), .i_d({w_op_sel, w_winner}), .o_q(w_opid)
  );
  assign w_op = w_opid[IDW];
  assign w_id = w_opid[IDW-1:0];

  // Subtract as A + ~B + 1 so carry-out doubles as "no borrow".
  assign w_bop = (w_op == OP_SUB) ? ~w_b : w_b;
  assign w_sum = {1'b0, w_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_op};
  assign w_ovf = (w_a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

  register #(.W(WIDTH+2)) u_reg_res (
    .clk(clk), .rst(rst), .i_en(r_state == EXEC),
    .i_d({w_ovf, w_sum[WIDTH], w_sum[WIDTH-1:0]}), .o_q(w_res_q)
  );

  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_result = w_res_q[WIDTH-1:0];
  assign bus.rsp_carry  = w_res_q[WIDTH];
  assign bus.rsp_ovf    = w_res_q[WIDTH+1];
  assign bus.rsp_id     = w_id;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: flags, round-robin order, backpressure, reset.
module tb_addsub_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  addsub_arbiter_if #(.WIDTH(16), .NREQ(4), .IDW(2)) bus ();

  addsub_arbiter #(.WIDTH(16), .NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b, input logic op);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
    bus.req_op[i]         = op;
  endtask

  // Present vmask, expect win granted, then follow the op through LOAD/EXEC/RESP.
  task automatic run_op(input string tag, input logic [3:0] vmask, input int win,
                        input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic [15:0] er, input logic ec, input logic ev);
    logic [3:0] onehot;
    onehot = 4'b0001 << win;
    set_lane(win, a, b, op);
    bus.req_valid = vmask;
    #1;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(onehot));
    tick();
    bus.req_valid[win] = 1'b0;
    chk({tag, ".lat1"}, 32'(bus.rsp_valid), 0);
    chk({tag, ".busy_ready"}, 32'(bus.req_ready), 0);
    tick();
    chk({tag, ".lat2"}, 32'(bus.rsp_valid), 0);
    tick();
    chk({tag, ".valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, ".result"}, 32'(bus.rsp_result), 32'(er));
    chk({tag, ".carry"}, 32'(bus.rsp_carry), 32'(ec));
    chk({tag, ".ovf"}, 32'(bus.rsp_ovf), 32'(ev));
    chk({tag, ".id"}, 32'(bus.rsp_id), 32'(win));
    tick();
    chk({tag, ".done"}, 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    int last;
    int got;
    logic [1:0] exp_ids [5];
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst.ready", 32'(bus.req_ready), 0);
    chk("rst.valid", 32'(bus.rsp_valid), 0);
    chk("rst.result", 32'(bus.rsp_result), 0);
    chk("rst.id", 32'(bus.rsp_id), 0);
    bus.req_valid = '0;
    rst = 1'b1;
    tick();

    // Single add, then flag/wrap cases; leaves rr_ptr at 0.
    run_op("add",     4'b0001, 0, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0);
    run_op("wrap",    4'b0010, 1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("povf",    4'b0100, 2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("borrow",  4'b1000, 3, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_op("novf",    4'b1000, 3, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // All requesters valid with rsp_ready high.
    for (int i = 0; i < 4; i++) set_lane(i, 16'(16'h0100 * (i + 1)), 16'(i), 1'b0);
    bus.req_valid = 4'b1111;
    last = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        chk("rr.id", 32'(bus.rsp_id), 32'(exp_ids[got]));
        chk("rr.result", 32'(bus.rsp_result),
            32'(16'h0100 * (exp_ids[got] + 1) + exp_ids[got]));
        if (got > 0) chk("rr.gap", 32'(c - last), 4);
        last = c;
        got++;
        if (got == 5) bus.req_valid = '0;
      end
    end
    chk("rr.count", 32'(got), 5);
    bus.req_valid = '0;
    tick();

    // Backpressure: hold the response for 5 cycles; rr_ptr is 1 here.
    bus.rsp_ready = 1'b0;
    set_lane(2, 16'h1000, 16'h0234, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    chk("bp.ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = 4'b0001;
      #1;
      chk("bp.valid", 32'(bus.rsp_valid), 1);
      chk("bp.result", 32'(bus.rsp_result), 32'h1234);
      chk("bp.id", 32'(bus.rsp_id), 2);
      chk("bp.noready", 32'(bus.req_ready), 0);
      tick();
    end
    bus.req_valid = '0;
    chk("bp.still", 32'(bus.rsp_valid), 1);
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp.done", 32'(bus.rsp_valid), 0);

    // Reset during EXEC; rr_ptr is 3, so req 1 wins first.
    set_lane(1, 16'h0042, 16'h0001, 1'b0);
    bus.req_valid = 4'b0010;
    #1;
    chk("mid.ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    tick();
    chk("mid.exec", 32'(bus.rsp_valid), 0);
    bus.req_valid = 4'b0100;
    rst = 1'b0;
    #1;
    chk("mid.rst_valid", 32'(bus.rsp_valid), 0);
    chk("mid.rst_ready", 32'(bus.req_ready), 0);
    chk("mid.rst_result", 32'(bus.rsp_result), 0);
    tick();
    chk("mid.no_rsp", 32'(bus.rsp_valid), 0);
    rst = 1'b1;
    run_op("mid.req2", 4'b0100, 2, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);

    // rr_ptr now 3; serve req 1 to move it to 2, then 1 and 3 contend.
    run_op("skip.pre", 4'b0010, 1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("skip.3",   4'b1010, 3, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("skip.1",   4'b0010, 1, 16'h0010, 16'h0020, 1'b1, 16'hFFF0, 1'b0, 1'b0);
    bus.req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end
endmodule
